wb_iq_sample_fifo: RTL and testbench

- Wishbone slave that buffers host-written baseband I/Q sample pairs.
- Replays them to a pair of DAC-width outputs at a programmable sample rate.
- Sits upstream of the I/Q DAC output stage: feeds registered I and Q codes plus a sample strobe to the modulator datapath.
- Occupies its own 8-word page on the UART-to-Wishbone bus, alongside the control and FM generator slaves.

---
 rtl/wb_iq_sample_fifo.sv | 198 +++++++++++++++++++
 tb/tb_wb_iq_sample_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_iq_sample_fifo.sv
// wb_iq_sample_fifo
//   Wishbone slave buffering host-written I/Q sample pairs in a circular FIFO.
//   A programmable down-counter paces pops that drive registered I/Q DAC codes.
//
//   Optional build macro: IQ_FIFO_LOOP_EN enables loop (circular replay) mode
//   on CTRL bit1. Without it, CTRL bit1 is ignored on write and reads 0.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_wb_cyc/stb/we/addr    Wishbone request (stb already page-qualified)
//   i_wb_data               write data
//   o_wb_ack                ack one cycle after each stb
//   o_wb_stall              always 0
//   o_wb_data               read data, valid in ack cycle
//   o_dac_a / o_dac_b       registered I / Q codes, offset binary
//   o_sample_stb            pulses in the cycle the DAC codes update
//   o_underrun              sticky underrun flag
//
// Register map (word address)
//   0 DATA   W: push {I=data[25:16], Q=data[9:0]}       R: 0
//   1 RATE   R/W sample period - 1
//   2 CTRL   W: b0 enable, b1 loop, b4 w1c underrun, b5 w1c overflow
//            R: b0 enable, b1 loop, b2 empty, b3 full, b4 underrun, b5 overflow
//   3 LEVEL  R: occupancy
//   4-7      acked, read 0, writes ignored
module wb_iq_sample_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DAC_WIDTH  = 10,
    parameter int RATE_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [2:0]            i_wb_addr,
    input  logic [31:0]           i_wb_data,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    output logic [31:0]           o_wb_data,
    output logic [DAC_WIDTH-1:0]  o_dac_a,
    output logic [DAC_WIDTH-1:0]  o_dac_b,
    output logic                  o_sample_stb,
    output logic                  o_underrun
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PW     = DEPTH_LOG2 + 1;
    localparam int WORD_W = 2 * DAC_WIDTH;
    localparam logic [DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RATE_WIDTH-1:0] rate_q, rate_d, cnt_q, cnt_d;
    logic                  enable_q, enable_d;
    logic                  loop_q;
    logic                  underrun_q, underrun_d, overflow_q, overflow_d;
    logic [DAC_WIDTH-1:0]  dac_a_q, dac_a_d, dac_b_q, dac_b_d;
    logic                  stb_q, stb_d, ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  mem_we;
    logic [WORD_W-1:0]     mem_wdata, head;
    logic [PW-1:0]         level;
    logic                  req, bus_wr, bus_rd, empty, full, tick, pop;
    logic                  data_wr, ctrl_wr, push_ok, loop_back;
    logic                  unused_bits;

`ifdef IQ_FIFO_LOOP_EN
    logic loop_d;
`else
    assign loop_q = 1'b0;
`endif

    assign unused_bits = ^i_wb_data;

    assign req     = i_wb_cyc & i_wb_stb;
    assign bus_wr  = req & i_wb_we;
    assign bus_rd  = req & ~i_wb_we;
    assign data_wr = bus_wr && (i_wb_addr == 3'd0);
    assign ctrl_wr = bus_wr && (i_wb_addr == 3'd2);

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == PW'(DEPTH));
    assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign tick      = enable_q && (cnt_q == '0);
    assign pop       = tick & ~empty;
    // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
    assign push_ok   = data_wr & ~loop_q & (~full | pop);
    assign loop_back = pop & loop_q;

    always_comb begin
        mem_we     = push_ok | loop_back;
        mem_wdata  = loop_back ? head
                               : {i_wb_data[16 +: DAC_WIDTH], i_wb_data[0 +: DAC_WIDTH]};
        wr_ptr_d   = wr_ptr_q + PW'(mem_we);
        rd_ptr_d   = rd_ptr_q + PW'(pop);

        rate_d     = rate_q;
        enable_d   = enable_q;
`ifdef IQ_FIFO_LOOP_EN
        loop_d     = loop_q;
`endif
        underrun_d = underrun_q;
        overflow_d = overflow_q;

        if (bus_wr && (i_wb_addr == 3'd1))
            rate_d = i_wb_data[RATE_WIDTH-1:0];

        if (ctrl_wr) begin
            enable_d = i_wb_data[0];
`ifdef IQ_FIFO_LOOP_EN
            loop_d   = i_wb_data[1];
`endif
            if (i_wb_data[4]) underrun_d = 1'b0;
            if (i_wb_data[5]) overflow_d = 1'b0;
        end
        // Set beats a same-cycle write-1-clear.
        if (tick & empty)         underrun_d = 1'b1;
        if (data_wr & ~push_ok)   overflow_d = 1'b1;

        // Counter parks at RATE while disabled so enabling starts a full period.
        if (!enable_q || (cnt_q == '0))
            cnt_d = rate_q;
        else
            cnt_d = cnt_q - 1'b1;

        dac_a_d = dac_a_q;
        dac_b_d = dac_b_q;
        if (pop) begin
            dac_a_d = head[WORD_W-1 -: DAC_WIDTH];
            dac_b_d = head[DAC_WIDTH-1:0];
        end
        stb_d = pop;

        ack_d   = req;
        rdata_d = '0;
        if (bus_rd) begin
            case (i_wb_addr)
                3'd1:    rdata_d = 32'(rate_q);
                3'd2:    rdata_d = {26'd0, overflow_q, underrun_q, full, empty,
                                    loop_q, enable_q};
                3'd3:    rdata_d = 32'(level);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we && !i_reset)
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= mem_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rate_q     <= '0;
            cnt_q      <= '0;
            enable_q   <= 1'b0;
`ifdef IQ_FIFO_LOOP_EN
            loop_q     <= 1'b0;
`endif
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            dac_a_q    <= MIDSCALE;
            dac_b_q    <= MIDSCALE;
            stb_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            enable_q   <= enable_d;
`ifdef IQ_FIFO_LOOP_EN
            loop_q     <= loop_d;
`endif
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            dac_a_q    <= dac_a_d;
            dac_b_q    <= dac_b_d;
            stb_q      <= stb_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_wb_ack     = ack_q;
    assign o_wb_stall   = 1'b0;
    assign o_wb_data    = rdata_q;
    assign o_dac_a      = dac_a_q;
    assign o_dac_b      = dac_b_q;
    assign o_sample_stb = stb_q;
    assign o_underrun   = underrun_q;
endmodule

// File: tb/tb_wb_iq_sample_fifo.sv
module tb_wb_iq_sample_fifo;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [2:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_wb_ack, o_wb_stall, o_sample_stb, o_underrun;
    logic [31:0] o_wb_data;
    logic [9:0]  o_dac_a, o_dac_b;

    int total = 0;
    int bad = 0;
    logic [9:0] exp_i [0:71];
    logic [9:0] exp_q [0:71];

    wb_iq_sample_fifo dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
        .o_dac_a(o_dac_a), .o_dac_b(o_dac_b),
        .o_sample_stb(o_sample_stb), .o_underrun(o_underrun)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] word(input int k);
        return {6'd0, exp_i[k], 6'd0, exp_q[k]};
    endfunction

    // Called at a negedge; returns at the negedge of the ack cycle.
    task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                        output logic ack, output logic [31:0] r);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = w; i_wb_addr = a; i_wb_data = d;
        @(posedge i_clk);
        @(negedge i_clk);
        ack = o_wb_ack;
        r = o_wb_data;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic ack;
        logic [31:0] r;
        xfer(1'b1, a, d, ack, r);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] r);
        logic ack;
        xfer(1'b0, a, 32'd0, ack, r);
    endtask

    task automatic wait_stb(input int bound, output int n);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_sample_stb && n <= bound);
    endtask

    task automatic test_reset;
        logic ack;
        logic [31:0] r;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        total++; if (o_dac_a !== 10'h200 || o_dac_b !== 10'h200) begin bad++;
            $display("FAIL reset_dac got=%h/%h want=200/200", o_dac_a, o_dac_b); end
        total++; if (o_sample_stb !== 1'b0 || o_wb_ack !== 1'b0 || o_underrun !== 1'b0) begin bad++;
            $display("FAIL reset_flags got stb=%b ack=%b und=%b want 0", o_sample_stb, o_wb_ack, o_underrun); end
        total++; if (o_wb_data !== 32'h0 || o_wb_stall !== 1'b0) begin bad++;
            $display("FAIL reset_bus got data=%h stall=%b want 0", o_wb_data, o_wb_stall); end
        xfer(1'b0, 3'd2, 32'd0, ack, r);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL ack_latency got=%b want=1", ack); end
        total++; if (r !== 32'h4) begin bad++; $display("FAIL reset_ctrl got=%h want=4", r); end
        @(negedge i_clk);
        total++; if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL ack_single got=%b want=0", o_wb_ack); end
        rd(3'd3, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_level got=%h want=0", r); end
        rd(3'd1, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_rate got=%h want=0", r); end
    endtask

    task automatic test_stream;
        logic [31:0] r;
        int n;
        logic saw;
        wr(3'd0, 32'h01230045);
        wr(3'd0, 32'h03FF0000);
        wr(3'd1, 32'hFFFF0003);
        rd(3'd1, r);
        total++; if (r !== 32'h3) begin bad++; $display("FAIL rate_rb got=%h want=3", r); end
        wr(3'd6, 32'hFFFFFFFF);
        rd(3'd6, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL unused_addr got=%h want=0", r); end
        rd(3'd3, r);
        total++; if (r !== 32'h2) begin bad++; $display("FAIL level2 got=%h want=2", r); end
        wr(3'd2, 32'h1);
        wait_stb(10, n);
        total++; if (n !== 4) begin bad++; $display("FAIL first_pop_delay got=%0d want=4", n); end
        total++; if (o_dac_a !== 10'h123 || o_dac_b !== 10'h045) begin bad++;
            $display("FAIL sample0 got=%h/%h want=123/045", o_dac_a, o_dac_b); end
        wait_stb(10, n);
        total++; if (n !== 4) begin bad++; $display("FAIL period got=%0d want=4", n); end
        total++; if (o_dac_a !== 10'h3FF || o_dac_b !== 10'h000) begin bad++;
            $display("FAIL sample1 got=%h/%h want=3ff/000", o_dac_a, o_dac_b); end
        saw = 1'b0;
        repeat (4) begin @(negedge i_clk); saw |= o_sample_stb; end
        total++; if (saw !== 1'b0 || o_underrun !== 1'b1) begin bad++;
            $display("FAIL underrun got stb=%b und=%b want stb=0 und=1", saw, o_underrun); end
        total++; if (o_dac_a !== 10'h3FF || o_dac_b !== 10'h000) begin bad++;
            $display("FAIL underrun_hold got=%h/%h want=3ff/000", o_dac_a, o_dac_b); end
        wr(3'd2, 32'h11);
        total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL und_clear got=%b want=0", o_underrun); end
        rd(3'd2, r);
        total++; if (r !== 32'h5) begin bad++; $display("FAIL ctrl_after_clear got=%h want=5", r); end
        wr(3'd2, 32'h0);
        rd(3'd2, r);
        total++; if (r !== 32'h4) begin bad++; $display("FAIL ctrl_disabled got=%h want=4", r); end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        for (int k = 0; k < 64; k++) wr(3'd0, word(k));
        wr(3'd0, 32'h02AA0155);
        rd(3'd3, r);
        total++; if (r !== 32'd64) begin bad++; $display("FAIL level_full got=%0d want=64", r); end
        rd(3'd2, r);
        total++; if (r !== 32'h28) begin bad++; $display("FAIL ctrl_full got=%h want=28", r); end
    endtask

    task automatic test_full_rate0;
        logic [31:0] r;
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h21);
        for (int j = 1; j <= 8; j++) begin
            wr(3'd0, word(63 + j));
            total++; if (o_sample_stb !== 1'b1 || o_dac_a !== exp_i[j-1] || o_dac_b !== exp_q[j-1]) begin bad++;
                $display("FAIL full_pushpop[%0d] got stb=%b %h/%h want 1 %h/%h", j-1, o_sample_stb,
                         o_dac_a, o_dac_b, exp_i[j-1], exp_q[j-1]); end
        end
        wr(3'd2, 32'h0);
        total++; if (o_sample_stb !== 1'b1 || o_dac_a !== exp_i[8] || o_dac_b !== exp_q[8]) begin bad++;
            $display("FAIL pop_on_disable got stb=%b %h/%h want 1 %h/%h", o_sample_stb,
                     o_dac_a, o_dac_b, exp_i[8], exp_q[8]); end
        rd(3'd3, r);
        total++; if (r !== 32'd63) begin bad++; $display("FAIL level_pushpop got=%0d want=63", r); end
        rd(3'd2, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL ctrl_pushpop got=%h want=0", r); end
    endtask

    task automatic test_drain;
        logic [31:0] r;
        wr(3'd2, 32'h1);
        for (int i = 9; i < 72; i++) begin
            @(negedge i_clk);
            total++; if (o_sample_stb !== 1'b1 || o_dac_a !== exp_i[i] || o_dac_b !== exp_q[i]) begin bad++;
                $display("FAIL drain[%0d] got stb=%b %h/%h want 1 %h/%h", i, o_sample_stb,
                         o_dac_a, o_dac_b, exp_i[i], exp_q[i]); end
        end
        @(negedge i_clk);
        total++; if (o_sample_stb !== 1'b0 || o_underrun !== 1'b1) begin bad++;
            $display("FAIL drain_end got stb=%b und=%b want 0/1", o_sample_stb, o_underrun); end
        wr(3'd2, 32'h30);
        total++; if (o_underrun !== 1'b1) begin bad++; $display("FAIL set_priority got=%b want=1", o_underrun); end
        wr(3'd2, 32'h30);
        total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL und_clear2 got=%b want=0", o_underrun); end
        rd(3'd3, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL level_drained got=%h want=0", r); end
        total++; if (o_dac_a !== exp_i[71] || o_dac_b !== exp_q[71]) begin bad++;
            $display("FAIL no_65th got=%h/%h want=%h/%h", o_dac_a, o_dac_b, exp_i[71], exp_q[71]); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        int n;
        for (int k = 0; k < 12; k++) wr(3'd0, word(k));
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h1);
        wait_stb(10, n);
        wait_stb(10, n);
        total++; if (n !== 2 || o_dac_a !== exp_i[1]) begin bad++;
            $display("FAIL pre_reset got n=%0d dac=%h want 2 %h", n, o_dac_a, exp_i[1]); end
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 3'd3; i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        total++; if (o_wb_ack !== 1'b0 || o_sample_stb !== 1'b0) begin bad++;
            $display("FAIL mid_reset_flags got ack=%b stb=%b want 0/0", o_wb_ack, o_sample_stb); end
        total++; if (o_dac_a !== 10'h200 || o_dac_b !== 10'h200) begin bad++;
            $display("FAIL mid_reset_dac got=%h/%h want=200/200", o_dac_a, o_dac_b); end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_reset = 1'b0;
        rd(3'd3, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_reset_level got=%h want=0", r); end
        rd(3'd1, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_reset_rate got=%h want=0", r); end
        rd(3'd2, r);
        total++; if (r !== 32'h4) begin bad++; $display("FAIL mid_reset_ctrl got=%h want=4", r); end
    endtask

`ifdef IQ_FIFO_LOOP_EN
    task automatic test_loop;
        logic [31:0] r;
        int n;
        logic [9:0] ai [0:2];
        ai[0] = 10'h011; ai[1] = 10'h033; ai[2] = 10'h055;
        wr(3'd0, 32'h00110022);
        wr(3'd0, 32'h00330044);
        wr(3'd0, 32'h00550066);
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h3);
        rd(3'd2, r);
        total++; if (r !== 32'h3) begin bad++; $display("FAIL loop_ctrl got=%h want=3", r); end
        for (int i = 0; i < 6; i++) begin
            wait_stb(10, n);
            total++; if (n !== ((i == 0) ? 1 : 2) || o_dac_a !== ai[i%3] || o_dac_b !== ai[i%3] + 10'h11) begin bad++;
                $display("FAIL loop_seq[%0d] got n=%0d %h/%h want %h/%h", i, n, o_dac_a, o_dac_b,
                         ai[i%3], ai[i%3] + 10'h11); end
        end
        wr(3'd0, 32'h01230045);
        rd(3'd3, r);
        total++; if (r !== 32'h3) begin bad++; $display("FAIL loop_level got=%h want=3", r); end
        rd(3'd2, r);
        total++; if (r !== 32'h23) begin bad++; $display("FAIL loop_ovf got=%h want=23", r); end
        wr(3'd2, 32'h20);
        rd(3'd3, r);
        total++; if (r !== 32'h3) begin bad++; $display("FAIL loop_off_level got=%h want=3", r); end
        rd(3'd2, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL loop_off_ctrl got=%h want=0", r); end
    endtask
`else
    task automatic test_no_loop;
        logic [31:0] r;
        int n;
        wr(3'd0, 32'h00110022);
        wr(3'd0, 32'h00330044);
        wr(3'd0, 32'h00550066);
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h3);
        rd(3'd2, r);
        total++; if (r !== 32'h1) begin bad++; $display("FAIL noloop_ctrl got=%h want=1", r); end
        wait_stb(10, n);
        total++; if (n !== 1 || o_dac_a !== 10'h011 || o_dac_b !== 10'h022) begin bad++;
            $display("FAIL noloop_a got n=%0d %h/%h want 1 011/022", n, o_dac_a, o_dac_b); end
        wait_stb(10, n);
        total++; if (n !== 2 || o_dac_a !== 10'h033 || o_dac_b !== 10'h044) begin bad++;
            $display("FAIL noloop_b got n=%0d %h/%h want 2 033/044", n, o_dac_a, o_dac_b); end
        wait_stb(10, n);
        total++; if (n !== 2 || o_dac_a !== 10'h055 || o_dac_b !== 10'h066) begin bad++;
            $display("FAIL noloop_c got n=%0d %h/%h want 2 055/066", n, o_dac_a, o_dac_b); end
        repeat (2) @(negedge i_clk);
        total++; if (o_underrun !== 1'b1 || o_sample_stb !== 1'b0) begin bad++;
            $display("FAIL noloop_drain got und=%b stb=%b want 1/0", o_underrun, o_sample_stb); end
        rd(3'd3, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL noloop_level got=%h want=0", r); end
        wr(3'd2, 32'h30);
        wr(3'd2, 32'h30);
    endtask
`endif

    initial begin
        for (int k = 0; k < 72; k++) begin
            exp_i[k] = 10'(k * 7 + 1);
            exp_q[k] = 10'(k ^ 32'h155);
        end
        test_reset();
        test_stream();
        test_overflow();
        test_full_rate0();
        test_drain();
        test_reset_mid();
`ifdef IQ_FIFO_LOOP_EN
        test_loop();
`else
        test_no_loop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
